// File: rtl/bitworks_pkg.sv
// Shared types for the NAND-built logic pipeline.
package bitworks_pkg;

  localparam int unsigned LOGIC_OP_W = 3;
  localparam int unsigned OCC_W      = 2;

  // Operation select for the logic unit
  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_NOT  = 3'd0,
    OP_NAND = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } logic_op_e;

  // Buffer occupancy: nothing, main only, main plus skid
  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/myNAND.sv
// Two-input NAND primitive; every boolean function in the unit is built from it.
module myNAND (
  input  logic i_a,
  input  logic i_b,
  output logic o_y_c
);

  assign o_y_c = ~(i_a & i_b);

endmodule

// File: rtl/nand_logic_slice.sv
// One bit of the logic unit: all eight ops from NAND gates, selected by op.
module nand_logic_slice
  import bitworks_pkg::*;
(
  input  logic      i_a,
  input  logic      i_b,
  input  logic_op_e i_op,
  output logic      o_y_c
);

  logic w_not_a;
  logic w_not_b;
  logic w_nand;
  logic w_and;
  logic w_or;
  logic w_nor;
  logic w_xor_l;
  logic w_xor_r;
  logic w_xor;
  logic w_xnor;
  logic w_pass;

  myNAND u_not_a (.i_a(i_a),     .i_b(i_a),     .o_y_c(w_not_a));
  myNAND u_not_b (.i_a(i_b),     .i_b(i_b),     .o_y_c(w_not_b));
  myNAND u_nand  (.i_a(i_a),     .i_b(i_b),     .o_y_c(w_nand));
  myNAND u_and   (.i_a(w_nand),  .i_b(w_nand),  .o_y_c(w_and));
  myNAND u_or    (.i_a(w_not_a), .i_b(w_not_b), .o_y_c(w_or));
  myNAND u_nor   (.i_a(w_or),    .i_b(w_or),    .o_y_c(w_nor));

  // Classic four-gate XOR: the shared A NAND B term feeds both halves
  myNAND u_xor_l (.i_a(i_a),     .i_b(w_nand),  .o_y_c(w_xor_l));
  myNAND u_xor_r (.i_a(i_b),     .i_b(w_nand),  .o_y_c(w_xor_r));
  myNAND u_xor   (.i_a(w_xor_l), .i_b(w_xor_r), .o_y_c(w_xor));
  myNAND u_xnor  (.i_a(w_xor),   .i_b(w_xor),   .o_y_c(w_xnor));
  myNAND u_pass  (.i_a(w_not_a), .i_b(w_not_a), .o_y_c(w_pass));

  // Select the requested function
  always_comb begin
    o_y_c = 1'b0;
    case (i_op)
      OP_NOT:  o_y_c = w_not_a;
      OP_NAND: o_y_c = w_nand;
      OP_AND:  o_y_c = w_and;
      OP_OR:   o_y_c = w_or;
      OP_NOR:  o_y_c = w_nor;
      OP_XOR:  o_y_c = w_xor;
      OP_XNOR: o_y_c = w_xnor;
      OP_PASS: o_y_c = w_pass;
      default: o_y_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/nand_logic_pipe.sv
// One-cycle pipelined N-bit NAND logic unit with valid/ready, skid buffer
// and a saturating transfer counter.
module nand_logic_pipe
  import bitworks_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      inA,
  input  logic [WIDTH-1:0]      inB,
  input  logic [LOGIC_OP_W-1:0] inOp,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [WIDTH-1:0]      outY,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  outZero,
  output logic [COUNT_W-1:0]    outCount,
  input  logic                  inClear
);

  occ_e               r_state;
  occ_e               w_state_nxt;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [WIDTH-1:0]   r_main;
  logic [WIDTH-1:0]   r_skid;
  logic [COUNT_W-1:0] r_count;
  logic [WIDTH-1:0]   w_result;
  logic               w_accept;
  logic               w_emit;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;
  logic_op_e          w_op;

  assign w_op     = logic_op_e'(inOp);
  assign w_accept = inValid && r_in_ready;
  assign w_emit   = r_out_valid && outReady;

  // Bitwise datapath: one NAND slice per result bit
  for (genvar g = 0; g < WIDTH; g++) begin : g_slice
    nand_logic_slice u_slice (
      .i_a   (inA[g]),
      .i_b   (inB[g]),
      .i_op  (w_op),
      .o_y_c (w_result[g])
    );
  end

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy and buffer load controls
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_accept) begin
          w_load_main_in = 1'b1;
          w_state_nxt    = OCC_MAIN;
        end
      end
      OCC_MAIN: begin
        if (w_emit) begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
          end else begin
            w_state_nxt = OCC_EMPTY;
          end
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = OCC_FULL;
        end
      end
      OCC_FULL: begin
        // inReady is low here, so only a drain can happen
        if (w_emit) begin
          w_load_main_skid = 1'b1;
          w_state_nxt      = OCC_MAIN;
        end
      end
      default: begin
        w_state_nxt = OCC_EMPTY;
      end
    endcase
  end

  // Registered handshake flags, derived from the next occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= (w_state_nxt != OCC_EMPTY);
      r_in_ready  <= (w_state_nxt != OCC_FULL);
    end
  end

  // Main and skid data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_result;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_result;
      end
    end
  end

  // Saturating output-handshake counter; clear wins over a same-cycle count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inClear) begin
      r_count <= '0;
    end else if (w_emit && (r_count != {COUNT_W{1'b1}})) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign inReady  = r_in_ready;
  assign outValid = r_out_valid;
  assign outY     = r_main;
  assign outCount = r_count;
  assign outZero  = (r_main == '0);

endmodule

// File: doc/nand_logic_pipe.md
# nand_logic_pipe

Parametrised, pipelined N-bit logic unit in which every boolean function is built from `myNAND` instances. It is the successor to the single-bit NAND-based inverter: it adds width, seven more operations, a registered output with a valid/ready handshake and skid buffer, and a saturating transfer counter. It sits between operand sources and downstream datapath blocks as a full-throughput, one-cycle-latency logic stage.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥1).
- `COUNT_W`, default 16: width of the completed-transfer counter (≥1).

- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `inA`  input  WIDTH: operand A.
- `inB`  input  WIDTH: operand B; ignored by unary ops.
- `inOp`  input  3: operation select, type `logic_op_e`.
- `inValid`  input  1: input beat offered.
- `inReady`  output  1: unit can accept a beat.
- `outY`  output  WIDTH: registered result.
- `outValid`  output  1: `outY` holds a valid beat.
- `outReady`  input  1: downstream accepts the beat.
- `outZero`  output  1: `outY == 0`, combinational from `outY`.
- `outCount`  output  COUNT_W: saturating count of output handshakes.
- `inClear`  input  1: synchronous clear of `outCount`.

## Operation
- Ops: 0 NOT A = NAND(A,A); 1 NAND; 2 AND = NOT(NAND); 3 OR = NAND(NOT A, NOT B); 4 NOR = NOT(OR); 5 XOR = 4-NAND network; 6 XNOR = NOT(XOR); 7 PASS A = NOT(NOT A).
- All ops are bitwise, per bit; no carries, no width growth.
- Accept when `inValid && inReady`; result and op are captured together in the same beat.
- Emit when `outValid && outReady`.
- Storage: main register and one skid register.
  - Accept with main empty, or main draining this cycle → result to main.
  - Accept with main full and stalled → result to skid.
  - When main drains and skid is full → skid moves to main.
- `inReady` = NOT skid-valid, registered. No combinational path from `outReady` to `inReady`.
- `outValid` stays high and `outY` stays stable until the handshake completes.
- `outCount` increments by 1 per output handshake and saturates at all-ones.
- `inClear` has priority: a simultaneous handshake is not counted, so `outCount` becomes 0.
- Reset values: `outValid`=0, `outY`=0, `outZero`=1, `outCount`=0, `inReady`=1, skid empty.
- While `reset` is high, `inValid` and `outReady` are ignored.
- Reset asserted mid-stream discards both buffered beats.

## Timing
- Latency 1 cycle: a beat accepted at edge N is valid on `outY` after edge N.
- Throughput is one beat per cycle while `outReady` is held high.
- One stall cycle absorbs exactly one extra beat into skid. `inReady` falls the cycle after skid fills and rises the cycle after skid empties.
- Simultaneous accept and emit with skid empty: main reloads and occupancy is unchanged.
- `outZero` follows `outY` combinationally, in the same cycle.

## Structure
- Shared package `bitworks_pkg`:
  - `logic_op_e`: enum of the 8 ops, 3 bits.
  - `LOGIC_OP_W = 3`.
- Sub-module `nand_logic_slice`: 1-bit, all 8 ops built only from `myNAND` plus a mux on the op. Generated WIDTH times.
- Handshake/skid logic and the counter live in the top level.

## Test plan
1. Reset held 2 cycles, then released → `outValid`=0, `outY`=0x00, `outZero`=1, `outCount`=0, `inReady`=1.
2. WIDTH=8, A=0xCA, B=0x5C, ops 0–7 back-to-back with `outReady`=1 → outputs 0x35, 0xB7, 0x48, 0xDE, 0x21, 0x96, 0x69, 0xCA, one per cycle; `outCount`=8.
3. Stream continuously with `outReady` low for 3 cycles → exactly 2 beats are buffered, `inReady`=0 from the second stall cycle on, and there is no loss or duplication after release.
4. A=B=0xFF, op XOR → `outY`=0x00, `outZero`=1.
5. COUNT_W=3, 9 transfers → `outCount` saturates at 7. Then `inClear` in the same cycle as a transfer → `outCount`=0.
6. Reset asserted with main and skid full → next cycle `outValid`=0, `inReady`=1; the two held beats never appear.
